// File: rtl/regset_write_sequencer_pkg.sv
// Shared definitions for the register-set write sequencer.
// State encoding, default geometry and the hard-wired-zero address.
package regset_write_sequencer_pkg;

  localparam int RS_AW = 6;
  localparam int RS_DW = 32;

  // Register x0 is architecturally zero; writes to it are swallowed.
  localparam int X0_ADDR = 0;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/regset_bypass_mux.sv
// Per-read-port write-to-read forwarding for a read-first register set.
// Captures a same-cycle write to the address being read and substitutes
// it for the stale registered read data one cycle later.
module regset_bypass_mux
  import regset_write_sequencer_pkg::*;
#(
  parameter int AW = RS_AW,
  parameter int DW = RS_DW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          wg,
  input  logic [AW-1:0] ra,
  input  logic [DW-1:0] rs_rd,
  input  logic          rs_rg,
  output logic [DW-1:0] rd,
  output logic          rg
);

  logic          hit;
  logic [DW-1:0] fwd_d;
  logic          fwd_g;

  // Remember whether the read issued this cycle collides with the write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit   <= 1'b0;
      fwd_d <= '0;
      fwd_g <= 1'b0;
    end else begin
      hit   <= we && (ra == wa);
      fwd_d <= wd;
      fwd_g <= wg;
    end
  end

  assign rd = hit ? fwd_d : rs_rd;
  assign rg = hit ? fwd_g : rs_rg;

endmodule

// File: rtl/regset_write_sequencer.sv
// Write-port sequencer for the 2**AW-entry register set.
// After reset it zero-fills every entry (BRAM without preinit), then
// arbitrates the single write port between core writeback (priority,
// no back-pressure) and a valid/ready long-latency unit, with a
// starvation counter that stalls the core for one cycle.
// Optional same-cycle read forwarding: define REGSET_SEQ_BYPASS_EN.
module regset_write_sequencer
  import regset_write_sequencer_pkg::*;
#(
  parameter int AW           = RS_AW,
  parameter int DW           = RS_DW,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          wb_grubby,
  output logic          core_stall,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [AW-1:0] lu_addr,
  input  logic [DW-1:0] lu_data,
  input  logic          lu_grubby,
  output logic          busy,
  output logic          rs_we,
  output logic [AW-1:0] rs_wa,
  output logic [DW-1:0] rs_wd,
  output logic          rs_wg,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [DW-1:0] rs_rd1,
  input  logic [DW-1:0] rs_rd2,
  input  logic          rs_rg1,
  input  logic          rs_rg2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          rg1,
  output logic          rg2
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [0:0]    state;
  logic [AW-1:0] clr_cnt;
  logic [SW-1:0] starve_cnt;
  logic          lu_starved;

  assign busy       = (state == ST_CLEAR);
  assign lu_starved = (state == ST_RUN) && lu_valid && !lu_ready;

  // Write-port mux: sweep, then core over slow unit; x0 writes suppressed.
  always_comb begin
    rs_we    = 1'b0;
    rs_wa    = wb_addr;
    rs_wd    = wb_data;
    rs_wg    = wb_grubby;
    lu_ready = 1'b0;
    if (!rstn) begin
      rs_wa = '0;
      rs_wd = '0;
      rs_wg = 1'b0;
    end else if (state == ST_CLEAR) begin
      rs_we = 1'b1;
      rs_wa = clr_cnt;
      rs_wd = '0;
      rs_wg = 1'b0;
    end else if (wb_valid) begin
      rs_we = (wb_addr != AW'(X0_ADDR));
    end else if (lu_valid) begin
      lu_ready = 1'b1;
      rs_we    = (lu_addr != AW'(X0_ADDR));
      rs_wa    = lu_addr;
      rs_wd    = lu_data;
      rs_wg    = lu_grubby;
    end
  end

  // Zero-fill sweep over every address, then hand over to normal operation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == {AW{1'b1}})
        state <= ST_RUN;
    end
  end

  // Starvation tracking; stall lands in the cycle the count hits LIMIT-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
      core_stall <= 1'b0;
    end else begin
      if (lu_starved) begin
        if (starve_cnt != SW'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
      core_stall <= lu_starved && (int'(starve_cnt) + 2 >= STARVE_LIMIT);
    end
  end

`ifndef SYNTHESIS
  // A core that ignores the stall still wins; make that visible in sim.
  always @(posedge clk) begin
    if (rstn && state == ST_RUN && core_stall && wb_valid)
      $error("regset_write_sequencer: wb_valid asserted during core_stall");
  end
`endif

`ifdef REGSET_SEQ_BYPASS_EN
  regset_bypass_mux #(.AW(AW), .DW(DW)) u_byp1 (
    .clk(clk), .rstn(rstn), .we(rs_we), .wa(rs_wa), .wd(rs_wd), .wg(rs_wg),
    .ra(ra1), .rs_rd(rs_rd1), .rs_rg(rs_rg1), .rd(rd1), .rg(rg1)
  );
  regset_bypass_mux #(.AW(AW), .DW(DW)) u_byp2 (
    .clk(clk), .rstn(rstn), .we(rs_we), .wa(rs_wa), .wd(rs_wd), .wg(rs_wg),
    .ra(ra2), .rs_rd(rs_rd2), .rs_rg(rs_rg2), .rd(rd2), .rg(rg2)
  );
`else
  // Read addresses only matter for forwarding; they go straight to the RAM.
  logic unused_ra;
  assign unused_ra = ^{ra1, ra2};
  assign rd1 = rs_rd1;
  assign rd2 = rs_rd2;
  assign rg1 = rs_rg1;
  assign rg2 = rs_rg2;
`endif

endmodule

// File: tb/tb_regset_write_sequencer.sv
// Directed bench for regset_write_sequencer with a read-first register-set
// model and a scoreboard of expected write-port values.
module tb_regset_write_sequencer;
  localparam int AW = 6, DW = 32, LIM = 8, DEPTH = 64;

  logic          clk = 1'b0, rstn = 1'b0;
  logic          wb_valid = 0, wb_grubby = 0, lu_valid = 0, lu_grubby = 0;
  logic [AW-1:0] wb_addr = '0, lu_addr = '0, ra1 = '0, ra2 = '0;
  logic [DW-1:0] wb_data = '0, lu_data = '0;
  logic          core_stall, lu_ready, busy, rs_we, rs_wg, rg1, rg2;
  logic [AW-1:0] rs_wa;
  logic [DW-1:0] rs_wd, rd1, rd2;
  logic [DW-1:0] rs_rd1, rs_rd2;
  logic          rs_rg1, rs_rg2;

  logic [DW-1:0] mem  [DEPTH];
  logic          gmem [DEPTH];

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          wg;
    logic          rdy;
  } wr_t;
  wr_t sbq[$];

  int checks = 0, errors = 0;

  regset_write_sequencer #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rstn(rstn),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_grubby(wb_grubby),
    .core_stall(core_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .lu_grubby(lu_grubby), .busy(busy),
    .rs_we(rs_we), .rs_wa(rs_wa), .rs_wd(rs_wd), .rs_wg(rs_wg),
    .ra1(ra1), .ra2(ra2), .rs_rd1(rs_rd1), .rs_rd2(rs_rd2),
    .rs_rg1(rs_rg1), .rs_rg2(rs_rg2),
    .rd1(rd1), .rd2(rd2), .rg1(rg1), .rg2(rg2)
  );

  always #5 clk = ~clk;

  // Read-first registered register set.
  always @(posedge clk) begin
    if (rs_we) begin
      mem[rs_wa]  <= rs_wd;
      gmem[rs_wa] <= rs_wg;
    end
    rs_rd1 <= mem[ra1];
    rs_rg1 <= gmem[ra1];
    rs_rd2 <= mem[ra2];
    rs_rg2 <= gmem[ra2];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic wg, input logic lv, input logic [AW-1:0] la,
                       input logic [DW-1:0] ld, input logic lg);
    wb_valid = wv; wb_addr = wa; wb_data = wd; wb_grubby = wg;
    lu_valid = lv; lu_addr = la; lu_data = ld; lu_grubby = lg;
  endtask

  task automatic push(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic wg, input logic rdy);
    wr_t e;
    e.we = we; e.wa = wa; e.wd = wd; e.wg = wg; e.rdy = rdy;
    sbq.push_back(e);
  endtask

  task automatic check_wr(input string tag);
    wr_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, got none expected entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".we"},  rs_we,    e.we);
      chk({tag, ".wa"},  rs_wa,    e.wa);
      chk({tag, ".wd"},  rs_wd,    e.wd);
      chk({tag, ".wg"},  rs_wg,    e.wg);
      chk({tag, ".rdy"}, lu_ready, e.rdy);
    end
  endtask

  // Called right after rstn rises on a falling edge; returns at a falling edge.
  task automatic sweep(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      push(1'b1, AW'(i), '0, 1'b0, 1'b0);
      #1;
      check_wr(tag);
      chk({tag, ".busy"}, busy, 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, ".busy"},  busy,       1'b1);
    chk({tag, ".rdy"},   lu_ready,   1'b0);
    chk({tag, ".we"},    rs_we,      1'b0);
    chk({tag, ".wa"},    rs_wa,      '0);
    chk({tag, ".wd"},    rs_wd,      '0);
    chk({tag, ".wg"},    rs_wg,      1'b0);
    chk({tag, ".stall"}, core_stall, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp_rd;
    logic          exp_rg;
    logic          exp_stall;

    // Reset with a slow request pending: nothing may leak out.
    drive(1'b1, 6'd3, 32'h1, 1'b1, 1'b1, 6'd4, 32'h2, 1'b1);
    #1;
    reset_chk("rst");
    @(negedge clk);
    drive(0, '0, '0, 0, 0, '0, '0, 0);
    rstn = 1'b1;

    sweep("sweep", DEPTH);

    // First cycle after the sweep, idle.
    push(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check_wr("idle65");
    chk("idle65.busy", busy, 1'b0);
    chk("idle65.stall", core_stall, 1'b0);

    // Core beats the slow unit, then the slow unit gets its turn.
    @(negedge clk);
    drive(1, 6'd5, 32'h55, 1, 1, 6'd9, 32'h99, 0);
    push(1, 6'd5, 32'h55, 1, 0);
    #1; check_wr("prio_core");
    @(negedge clk);
    drive(0, '0, '0, 0, 1, 6'd9, 32'h99, 0);
    push(1, 6'd9, 32'h99, 0, 1);
    #1; check_wr("prio_lu");

    // Starvation: compliant core writes every cycle it is allowed to.
    for (int k = 1; k <= LIM; k++) begin
      @(negedge clk);
      exp_stall = (k == LIM);
      drive(!exp_stall, AW'(10 + k), DW'(k), 0, 1, 6'd20, 32'hABCD, 1);
      if (exp_stall) push(1, 6'd20, 32'hABCD, 1, 1);
      else           push(1, AW'(10 + k), DW'(k), 0, 0);
      #1;
      chk($sformatf("starve%0d.stall", k), core_stall, exp_stall);
      check_wr($sformatf("starve%0d", k));
    end
    // Counter restarted: one losing cycle must not stall.
    @(negedge clk);
    drive(1, 6'd3, 32'h33, 0, 1, 6'd4, 32'h44, 1);
    push(1, 6'd3, 32'h33, 0, 0);
    #1; chk("post_starve1.stall", core_stall, 1'b0); check_wr("post_starve1");
    @(negedge clk);
    drive(0, '0, '0, 0, 1, 6'd4, 32'h44, 1);
    push(1, 6'd4, 32'h44, 1, 1);
    #1; chk("post_starve2.stall", core_stall, 1'b0); check_wr("post_starve2");

    // Slow write to x0: handshake completes, no write.
    @(negedge clk);
    drive(0, '0, '0, 0, 1, 6'd0, 32'hDEADBEEF, 1);
    ra1 = 6'd0; ra2 = 6'd5;
    push(0, 6'd0, 32'hDEADBEEF, 1, 1);
    #1; check_wr("x0");
    @(negedge clk);
    drive(0, '0, '0, 0, 0, '0, '0, 0);
    push(0, '0, '0, 0, 0);
    #1; check_wr("x0_idle");
    chk("x0.rd1", rd1, 32'h0);
    chk("x0.rg1", rg1, 1'b0);
    chk("r5.rd2", rd2, 32'h55);
    chk("r5.rg2", rg2, 1'b1);

    // Same-cycle write and read of r7.
    @(negedge clk);
    drive(1, 6'd7, 32'h12345678, 1, 0, '0, '0, 0);
    ra1 = 6'd7; ra2 = 6'd7;
    push(1, 6'd7, 32'h12345678, 1, 0);
    #1; check_wr("byp_wr");
    @(negedge clk);
    drive(0, '0, '0, 0, 0, '0, '0, 0);
    push(0, '0, '0, 0, 0);
`ifdef REGSET_SEQ_BYPASS_EN
    exp_rd = 32'h12345678; exp_rg = 1'b1;
`else
    exp_rd = 32'h0;        exp_rg = 1'b0;
`endif
    #1; check_wr("byp_idle");
    chk("byp.rd1", rd1, exp_rd);
    chk("byp.rd2", rd2, exp_rd);
    chk("byp.rg1", rg1, exp_rg);
    chk("byp.rg2", rg2, exp_rg);
    @(negedge clk);
    #1;
    chk("r7.rd1", rd1, 32'h12345678);
    chk("r7.rg2", rg2, 1'b1);

    // Reset mid-sweep at clr_cnt=30, then a full sweep again.
    @(negedge clk);
    rstn = 1'b0;
    #1; reset_chk("rst2");
    @(negedge clk);
    rstn = 1'b1;
    sweep("part", 30);
    rstn = 1'b0;
    #1; reset_chk("rst_mid");
    @(negedge clk);
    rstn = 1'b1;
    sweep("resweep", DEPTH);
    push(0, '0, '0, 0, 0);
    #1; check_wr("resweep_end");
    chk("resweep_end.busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
